// File: rtl/fnd_scan_controller.sv
// Multiplexed 7-segment scan controller: freezes the time fields once per frame and
// scans them onto a 4- or 8-digit common-anode FND bank through registered outputs.
module fnd_scan_controller #(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 100_000,
  parameter int BLINK_TICKS = 500
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            msec,
  input  logic [6:0]            sec,
  input  logic [6:0]            min,
  input  logic [6:0]            hour,
  input  logic                  mode,
  input  logic                  dp_blink,
  input  logic                  blank_lz,
  output logic [7:0]            fnd_font,
  output logic [NUM_DIGITS-1:0] fnd_comm
);

  localparam int SEL_W = $clog2(NUM_DIGITS);
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [PRE_W-1:0] pre_cnt;
  logic [SEL_W-1:0] sel;
  logic [BLK_W-1:0] blink_cnt;
  logic             dp_phase;
  logic [6:0]       snap_msec, snap_sec, snap_min, snap_hour;
  logic             snap_mode;
  logic             tick, frame_end;

  logic [3:0]            digits [8];
  logic [2:0]            idx;
  logic [3:0]            cur;
  logic                  is_sep;
  logic [7:0]            font_nxt;
  logic [NUM_DIGITS-1:0] comm_nxt;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'h0:    seg7 = 8'hC0;
      4'h1:    seg7 = 8'hF9;
      4'h2:    seg7 = 8'hA4;
      4'h3:    seg7 = 8'hB0;
      4'h4:    seg7 = 8'h99;
      4'h5:    seg7 = 8'h92;
      4'h6:    seg7 = 8'h82;
      4'h7:    seg7 = 8'hF8;
      4'h8:    seg7 = 8'h80;
      4'h9:    seg7 = 8'h90;
      4'hA:    seg7 = 8'h88;
      4'hB:    seg7 = 8'h83;
      4'hC:    seg7 = 8'hC6;
      4'hD:    seg7 = 8'hA1;
      4'hE:    seg7 = 8'h86;
      default: seg7 = 8'h8E;
    endcase
  endfunction

  function automatic logic [3:0] ones(input logic [6:0] v);
    return 4'(v % 7'd10);
  endfunction

  function automatic logic [3:0] tens(input logic [6:0] v);
    return 4'((v / 7'd10) % 7'd10);
  endfunction

  assign tick      = (pre_cnt == PRE_W'(SCAN_DIV - 1));
  assign frame_end = tick && (sel == SEL_W'(NUM_DIGITS - 1));

  always_comb begin
    digits[0] = ones(snap_msec);
    digits[1] = tens(snap_msec);
    digits[2] = ones(snap_sec);
    digits[3] = tens(snap_sec);
    digits[4] = ones(snap_min);
    digits[5] = tens(snap_min);
    digits[6] = ones(snap_hour);
    digits[7] = tens(snap_hour);

    // The 4-digit bank shows either the low or the high half of the 8-digit map.
    idx = 3'(sel);
    if (NUM_DIGITS == 4) idx[2] = snap_mode;
    cur = digits[idx];

    is_sep = (int'(sel) == 2) ||
             ((NUM_DIGITS == 8) && ((int'(sel) == 4) || (int'(sel) == 6)));

    font_nxt = seg7(cur);
    if (is_sep) font_nxt[7] = ~dp_phase;
    if (blank_lz && (int'(sel) == NUM_DIGITS - 1) && (cur == 4'd0)) font_nxt = 8'hFF;

    comm_nxt = ~(NUM_DIGITS'(1) << sel);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt   <= '0;
      sel       <= '0;
      blink_cnt <= '0;
      dp_phase  <= 1'b1;
      snap_msec <= '0;
      snap_sec  <= '0;
      snap_min  <= '0;
      snap_hour <= '0;
      snap_mode <= 1'b0;
      fnd_comm  <= '1;
      fnd_font  <= 8'hFF;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;

      if (tick) sel <= (sel == SEL_W'(NUM_DIGITS - 1)) ? '0 : sel + 1'b1;

      if (frame_end) begin
        snap_msec <= msec;
        snap_sec  <= sec;
        snap_min  <= min;
        snap_hour <= hour;
        snap_mode <= mode;
      end

      // Steady separator holds the blink machinery parked at the DP-on phase.
      if (!dp_blink) begin
        blink_cnt <= '0;
        dp_phase  <= 1'b1;
      end else if (tick) begin
        if (blink_cnt == BLK_W'(BLINK_TICKS - 1)) begin
          blink_cnt <= '0;
          dp_phase  <= ~dp_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end

      fnd_comm <= comm_nxt;
      fnd_font <= font_nxt;
    end
  end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Bench for fnd_scan_controller: 4- and 8-digit instances share stimulus and are
// compared every clock against an arithmetic frame/slot model.
module tb_fnd_scan_controller;

  localparam int SD = 4;
  localparam int BT = 3;
  localparam logic [7:0] SEG [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] msec, sec, min, hour;
  logic       mode, dp_blink, blank_lz;
  logic [7:0] font4, font8;
  logic [3:0] comm4;
  logic [7:0] comm8;

  int total = 0;
  int bad   = 0;

  int k  = 0;
  int nb = 0;
  int s4 [5];
  int s8 [5];
  logic [7:0] seen4 [4];
  logic [7:0] seen8 [8];

  always #5 clk = ~clk;

  fnd_scan_controller #(.NUM_DIGITS(4), .SCAN_DIV(SD), .BLINK_TICKS(BT)) dut4 (
    .clk(clk), .reset(reset), .msec(msec), .sec(sec), .min(min), .hour(hour),
    .mode(mode), .dp_blink(dp_blink), .blank_lz(blank_lz),
    .fnd_font(font4), .fnd_comm(comm4)
  );

  fnd_scan_controller #(.NUM_DIGITS(8), .SCAN_DIV(SD), .BLINK_TICKS(BT)) dut8 (
    .clk(clk), .reset(reset), .msec(msec), .sec(sec), .min(min), .hour(hour),
    .mode(mode), .dp_blink(dp_blink), .blank_lz(blank_lz),
    .fnd_font(font8), .fnd_comm(comm8)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Fields pair up as (ones, tens); the 4-digit view picks the sec/msec or hour/min pair.
  function automatic int digit_val(input int n, input int d, input int sn [5]);
    int f;
    int v;
    f = d / 2;
    if (n == 4 && sn[4] != 0) f = f + 2;
    v = sn[f];
    return (d % 2 == 0) ? v % 10 : (v / 10) % 10;
  endfunction

  function automatic logic [7:0] exp_font(input int n, input int d, input int sn [5],
                                          input bit phase, input bit blz);
    int         v;
    logic [7:0] f;
    v = digit_val(n, d, sn);
    f = SEG[v];
    if (blz && d == n - 1 && v == 0) return 8'hFF;
    if (d == 2 || (n == 8 && (d == 4 || d == 6))) f[7] = ~phase;
    return f;
  endfunction

  task automatic step();
    int         slot, d4, d8;
    bit         phase;
    logic [3:0] ec4;
    logic [7:0] ef4, ec8, ef8;
    @(posedge clk);
    if (reset) begin
      ec4 = 4'hF; ef4 = 8'hFF; ec8 = 8'hFF; ef8 = 8'hFF;
      k = 0; nb = 0;
      s4 = '{0, 0, 0, 0, 0};
      s8 = '{0, 0, 0, 0, 0};
    end else begin
      k++;
      slot  = (k - 1) / SD;
      d4    = slot % 4;
      d8    = slot % 8;
      phase = ((nb / BT) % 2) == 0;
      ec4 = 4'(~(4'b1 << d4));
      ec8 = ~(8'b1 << d8);
      ef4 = exp_font(4, d4, s4, phase, blank_lz);
      ef8 = exp_font(8, d8, s8, phase, blank_lz);
      if (k % SD == 0) begin
        if (d4 == 3) s4 = '{int'(msec), int'(sec), int'(min), int'(hour), int'(mode)};
        if (d8 == 7) s8 = '{int'(msec), int'(sec), int'(min), int'(hour), int'(mode)};
        if (dp_blink) nb++;
      end
      if (!dp_blink) nb = 0;
    end
    #1;
    check("comm4", 16'(comm4), 16'(ec4));
    check("font4", 16'(font4), 16'(ef4));
    check("comm8", 16'(comm8), 16'(ec8));
    check("font8", 16'(font8), 16'(ef8));
    for (int i = 0; i < 4; i++) if (comm4[i] === 1'b0) seen4[i] = font4;
    for (int i = 0; i < 8; i++) if (comm8[i] === 1'b0) seen8[i] = font8;
  endtask

  task automatic wait_digit(input int d);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step();
      if (comm4 === 4'(~(4'b1 << d))) hit = 1'b1;
    end
    check($sformatf("wait_digit%0d", d), 16'(hit), 16'd1);
  endtask

  initial begin
    reset = 1'b1; msec = '0; sec = '0; min = '0; hour = '0;
    mode = 1'b0; dp_blink = 1'b0; blank_lz = 1'b0;
    step();
    step();
    check("rst_comm4", 16'(comm4), 16'h000F);
    check("rst_font4", 16'(font4), 16'h00FF);

    reset = 1'b0; sec = 7'd12; msec = 7'd34;
    step();
    check("rel_comm4", 16'(comm4), 16'h000E);
    check("rel_font4", 16'(font4), 16'h00C0);
    repeat (70) step();
    check("f1_d0", 16'(seen4[0]), 16'h0099);
    check("f1_d1", 16'(seen4[1]), 16'h00B0);
    check("f1_d2", 16'(seen4[2]), 16'h0024);
    check("f1_d3", 16'(seen4[3]), 16'h00F9);

    wait_digit(1);
    sec = 7'd45;
    wait_digit(3);
    check("mid_d2_old", 16'(seen4[2]), 16'h0024);
    check("mid_d3_old", 16'(seen4[3]), 16'h00F9);
    wait_digit(0);
    wait_digit(3);
    check("mid_d2_new", 16'(seen4[2]), 16'h0012);
    check("mid_d3_new", 16'(seen4[3]), 16'h0099);

    mode = 1'b1; hour = 7'd3; min = 7'd7; blank_lz = 1'b1;
    repeat (40) step();
    check("hm_d0", 16'(seen4[0]), 16'h00F8);
    check("hm_d1", 16'(seen4[1]), 16'h00C0);
    check("hm_d2", 16'(seen4[2]), 16'h0030);
    check("hm_d3_blank", 16'(seen4[3]), 16'h00FF);
    blank_lz = 1'b0;
    repeat (17) step();
    check("hm_d3_noblank", 16'(seen4[3]), 16'h00C0);

    hour = 7'd23; min = 7'd59; sec = 7'd8; msec = 7'd99;
    repeat (70) step();
    check("d8_0", 16'(seen8[0]), 16'h0090);
    check("d8_1", 16'(seen8[1]), 16'h0090);
    check("d8_2", 16'(seen8[2]), 16'h0000);
    check("d8_3", 16'(seen8[3]), 16'h00C0);
    check("d8_4", 16'(seen8[4]), 16'h0010);
    check("d8_5", 16'(seen8[5]), 16'h0092);
    check("d8_6", 16'(seen8[6]), 16'h0030);
    check("d8_7", 16'(seen8[7]), 16'h00A4);

    dp_blink = 1'b1;
    repeat (80) step();
    dp_blink = 1'b0;

    wait_digit(2);
    step();
    reset = 1'b1;
    step();
    check("midrst_comm4", 16'(comm4), 16'h000F);
    check("midrst_font4", 16'(font4), 16'h00FF);
    check("midrst_comm8", 16'(comm8), 16'h00FF);
    reset = 1'b0;
    step();
    check("postrst_comm4", 16'(comm4), 16'h000E);
    check("postrst_font4", 16'(font4), 16'h00C0);
    check("postrst_font8", 16'(font8), 16'h00C0);

    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        msec     = 7'($urandom_range(0, 127));
        sec      = 7'($urandom_range(0, 127));
        min      = ($urandom_range(0, 2) == 0) ? 7'($urandom_range(0, 9)) : 7'($urandom_range(0, 127));
        hour     = ($urandom_range(0, 2) == 0) ? 7'($urandom_range(0, 9)) : 7'($urandom_range(0, 127));
        mode     = 1'($urandom_range(0, 1));
        dp_blink = 1'($urandom_range(0, 1));
        blank_lz = 1'($urandom_range(0, 1));
      end
      reset = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
